// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI slice blocks.
// Burst length, error counter and W gate state types.
package axi_slice_pkg;

    localparam int unsigned AXI_LEN_W = 8;

    typedef logic [AXI_LEN_W-1:0] axi_len_t;
    typedef logic [7:0]           err_cnt_t;

    typedef enum logic {
        GATE_IDLE,
        GATE_BURST
    } gate_state_e;

    // Increment that sticks at all-ones.
    function automatic err_cnt_t err_cnt_inc(err_cnt_t v);
        return (v == '1) ? v : v + err_cnt_t'(1);
    endfunction

endpackage

// File: rtl/axi_w_burst_gate_fifo.sv
// Generic circular FIFO with optional fall-through.
// flush_i empties it synchronously; testmode_i is reserved.
module axi_w_burst_gate_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0]   MAX_CNT  = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q;
    logic [ADDR_DEPTH-1:0] wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign bypass  = FALL_THROUGH && (cnt_q == '0);
    assign full_o  = (cnt_q == MAX_CNT);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q;
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];

    assign wr_en = push_i && !full_o && !(bypass && pop_i);
    assign rd_en = pop_i && !empty_o && !bypass;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + {{ADDR_DEPTH{1'b0}}, wr_en}
                           - {{ADDR_DEPTH{1'b0}}, rd_en};
        end
    end

    // Storage array, write port only.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_w_burst_gate.sv
// Gates W beats by queued AW lengths and checks WLAST.
// Define AXI_W_LAST_FIX_EN to drive WLAST from the counted length.
module axi_w_burst_gate
    import axi_slice_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  axi_len_t              aw_len_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic                  w_last_i,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic                  w_last_o,
    output logic                  err_o,
    output err_cnt_t              err_cnt_o
);

    localparam int unsigned ADDR_D = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;

    gate_state_e     state_q;
    gate_state_e     state_d;
    axi_len_t        head_len;
    axi_len_t        beat_q;
    logic            q_full;
    logic            q_empty;
    logic [ADDR_D:0] q_usage;
    logic            push;
    logic            pop;
    logic            hs;
    logic            exp_last;
    logic            mismatch;
    logic            err_q;
    err_cnt_t        err_cnt_q;
    logic            unused_empty;

    assign unused_empty = q_empty;

    assign aw_ready_o = !q_full;
    assign push       = aw_valid_i && !q_full;
    assign hs         = w_valid_o && w_ready_i;
    assign exp_last   = (beat_q == head_len);
    assign pop        = hs && exp_last;
    assign mismatch   = hs && (w_last_i != exp_last);
    assign w_data_o   = w_data_i;

`ifdef AXI_W_LAST_FIX_EN
    assign w_last_o = exp_last;
`else
    assign w_last_o = w_last_i;
`endif

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

    axi_w_burst_gate_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (AXI_LEN_W),
        .DEPTH        (LEN_DEPTH),
        .ADDR_DEPTH   (ADDR_D)
    ) i_len_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .usage_o    (q_usage),
        .data_i     (aw_len_i),
        .push_i     (push),
        .data_o     (head_len),
        .pop_i      (pop)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and W handshake gating.
    always_comb begin
        state_d   = state_q;
        w_valid_o = 1'b0;
        w_ready_o = 1'b0;
        unique case (state_q)
            GATE_IDLE: begin
                if (push) begin
                    state_d = GATE_BURST;
                end
            end
            GATE_BURST: begin
                w_valid_o = w_valid_i;
                w_ready_o = w_ready_i;
                if (pop && !push && (q_usage == (ADDR_D+1)'(1))) begin
                    state_d = GATE_IDLE;
                end
            end
            default: state_d = GATE_IDLE;
        endcase
    end

    // Beat counter within the head burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else if (pop) begin
            beat_q <= '0;
        end else if (hs) begin
            beat_q <= beat_q + axi_len_t'(1);
        end
    end

    // WLAST mismatch pulse and saturating count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= mismatch;
            if (mismatch) begin
                err_cnt_q <= err_cnt_inc(err_cnt_q);
            end
        end
    end

endmodule

// File: doc/axi_w_burst_gate.md
AXI_W_BURST_GATE -- requirements
Module: axi_w_burst_gate

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of the packed W payload (data, strb and user).
REQ-002 Parameter LEN_DEPTH, default 4: number of outstanding AW burst lengths held; it SHALL be at least 1.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 aw_valid_i  in  1  AW length valid (from upstream AW slice).
REQ-007 aw_ready_o  out  1  AW length accepted.
REQ-008 aw_len_i  in  8  AXI burst length, beats minus one.
REQ-009 w_valid_i  in  1  upstream W beat valid.
REQ-010 w_ready_o  out  1  upstream W beat accepted.
REQ-011 w_data_i  in  DATA_WIDTH  upstream W payload.
REQ-012 w_last_i  in  1  upstream WLAST.
REQ-013 w_valid_o  out  1  W beat valid to downstream W slice.
REQ-014 w_ready_i  in  1  downstream W slice ready.
REQ-015 w_data_o  out  DATA_WIDTH  W payload to downstream.
REQ-016 w_last_o  out  1  WLAST to downstream.
REQ-017 err_o  out  1  one-cycle pulse: WLAST mismatch detected.
REQ-018 err_cnt_o  out  8  saturating count of mismatched beats.

Function
REQ-019 Length queue SHALL push aw_len_i on aw_valid_i & aw_ready_o, with aw_ready_o = queue not full.
REQ-020 Queue SHALL be non-fall-through: a length pushed in cycle N is visible at the head in cycle N+1 at the earliest.
REQ-021 State IDLE (queue empty) SHALL force w_valid_o=0 and w_ready_o=0.
REQ-022 State BURST (queue non-empty) SHALL give w_valid_o=w_valid_i, w_ready_o=w_ready_i and w_data_o=w_data_i, all combinational with zero latency.
REQ-023 An 8-bit beat counter SHALL increment on each downstream handshake (w_valid_o & w_ready_i).
REQ-024 expected_last SHALL equal (beat counter == head length).
REQ-025 A handshake with expected_last=1 SHALL pop the queue and clear the counter in the same edge.
REQ-026 The block SHALL return to IDLE only if the queue is then empty.
REQ-027 aw_len_i=0 SHALL produce a one-beat burst.
REQ-028 aw_len_i=255 SHALL produce 256 beats with no counter overflow.
REQ-029 Simultaneous push and pop SHALL both take effect; queue occupancy SHALL be unchanged.
REQ-030 A push while full SHALL be impossible, since aw_ready_o=0 then.
REQ-031 A handshake with w_last_i != expected_last SHALL assert err_o in the following cycle.
REQ-032 The same mismatch SHALL increment err_cnt_o, saturating at 255.
REQ-033 Burst tracking SHALL always follow the counted length, never w_last_i.
REQ-034 w_data_o and w_last_o SHALL be don't-care while w_valid_o=0.

Reset
REQ-035 While rst_ni=0 the queue SHALL be emptied, the counter cleared, and the state set to IDLE.
REQ-036 While rst_ni=0 err_o=0 and err_cnt_o=0; after release aw_ready_o=1, w_valid_o=0 and w_ready_o=0.
REQ-037 Reset asserted mid-burst SHALL discard all pending lengths with no err_o pulse.

Configuration
REQ-038 With AXI_W_LAST_FIX_EN defined, w_last_o SHALL equal expected_last, so downstream always sees corrected bursts.
REQ-039 Without AXI_W_LAST_FIX_EN, w_last_o SHALL equal w_last_i; mismatch detection and err_o/err_cnt_o SHALL behave identically in both builds.

Structure
REQ-040 Package axi_slice_pkg SHALL hold AXI_LEN_W=8, typedef axi_len_t (8 bits) and typedef err_cnt_t (8 bits).
REQ-041 The length queue SHALL be one instance of the codebase generic fifo with FALL_THROUGH=0, DATA_WIDTH=AXI_LEN_W, DEPTH=LEN_DEPTH, flush_i=0 and testmode_i=0.
REQ-042 The counter, state and error logic SHALL be local to the module.

Verification
REQ-043 AW len=3, then 4 W beats with WLAST on beat 4, ready=1 -> 4 beats pass, w_last_o only on beat 4, queue empty after, err_cnt_o=0.
REQ-044 Five AW (len 0) pushed with no W and LEN_DEPTH=4 -> aw_ready_o=0 after 4th push; 5th accepted only after the first beat drains.
REQ-045 AW len=1, W beats with w_last_i=1 on beat 1 -> err_o pulses once, err_cnt_o=1.
REQ-045a Same stimulus as REQ-045, w_last_o -> 0 on beat 1 and 1 on beat 2 with the macro; 1 on beat 1 without it.
REQ-046 300 single-beat mismatched bursts -> err_cnt_o saturates at 255.
REQ-047 AW len=7, rst_ni pulsed low after 3 beats -> aw_ready_o=1, w_valid_o=0, counter 0; next AW len=0 with one beat completes cleanly.
